corner_detect: RTL and testbench
================================

# corner_detect

Per-frame marker corner finder. Scans the incoming camera/VGA pixel stream, classifies each pixel as marker or background by colour threshold, and tracks the four extreme marker pixels of the frame. At frame end it publishes them as `top_left`/`top_right`/`bot_left`/`bot_right` XY. These outputs feed the overlay path that draws the rotated and scaled image between the detected corners.

## Interface
- `p_h_active`, 640: active pixels per line; pixels with `VGA_X >= p_h_active` are ignored.
- `p_v_active`, 480: active lines; the last pixel of a frame is (`p_h_active-1`, `p_v_active-1`).
- `p_r_min`, 8'd160: a pixel is marker only if `R >= p_r_min`.
- `p_g_max`, 8'd80: a pixel is marker only if `G <= p_g_max`.
- `p_b_max`, 8'd80: a pixel is marker only if `B <= p_b_max`.
- `p_min_count`, 16'd16: minimum marker pixels in a frame for that frame to count as valid.

Ports:
- `clk`  in  1  system clock; one clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pixel_valid`  in  1  the `VGA_X`/`VGA_Y`/`R`/`G`/`B` inputs carry a pixel this cycle.
- `VGA_X`, `VGA_Y`  in  11 each  unsigned pixel coordinate.
- `R`, `G`, `B`  in  8 each  pixel colour.
- `top_left_x`, `top_left_y`, `top_right_x`, `top_right_y`, `bot_left_x`, `bot_left_y`, `bot_right_x`, `bot_right_y`  out  11 each  registered corner coordinates.
- `corners_valid`  out  1  high when the last completed frame had at least `p_min_count` marker pixels.
- `update`  out  1  single-cycle pulse when the corner outputs were reloaded.
- `pixel_count`  out  16  marker count of the last completed frame, saturating at 16'hFFFF.

## Operation
- States: SYNC and SCAN. The block is in SYNC after reset.
  - SYNC: ignore all pixels until `pixel_valid` arrives with (0,0), then go to SCAN. The (0,0) pixel is accumulated.
  - SCAN: accumulate every valid active pixel.
  - Valid (0,0) while in SCAN (truncated frame): discard the accumulators, re-initialise them with this pixel, and stay in SCAN. No `update` is generated.
  - Last pixel while in SCAN: do the frame-end actions below, then go to SYNC.
- Per-pixel keys:
  - `s = VGA_X + VGA_Y`: 12-bit unsigned.
  - `d = VGA_X - VGA_Y`: 12-bit signed.
- Accumulator initial values:
  - min_s = 12'hFFF, max_s = 0.
  - min_d = +2047, max_d = -2048.
  - count = 0.
- Corner mapping for each marker pixel. Comparisons are strict, so on a tie the first pixel in raster order wins.
  - s < min_s: this pixel becomes top_left.
  - s > max_s: this pixel becomes bot_right.
  - d > max_d: this pixel becomes top_right.
  - d < min_d: this pixel becomes bot_left.
  - count increments, saturating.
- Frame end (the last pixel is included in the result):
  - If final count >= `p_min_count`: load all eight corner outputs from the accumulators and set `corners_valid` = 1.
  - Otherwise: hold the corner outputs and clear `corners_valid`.
  - In both cases: load `pixel_count` and pulse `update`, then re-initialise the accumulators.
- Reset values:
  - `top_left` = (0,0).
  - `top_right` = (`p_h_active-1`, 0).
  - `bot_left` = (0, `p_v_active-1`).
  - `bot_right` = (`p_h_active-1`, `p_v_active-1`).
  - `corners_valid` = 0, `update` = 0, `pixel_count` = 0.
  - Accumulators at initial values; state = SYNC.
- Reset asserted mid-frame: everything returns to reset values immediately, and the partial frame is lost.

## Timing
- Classification and the compare/update of the accumulators happen in the same cycle the pixel is sampled. The block accepts one pixel per clock and never back-pressures.
- Output latency: the corner outputs, `pixel_count` and `corners_valid` change on the clock edge that samples the last pixel. `update` is high for exactly the cycle after that edge.
- Back-to-back frames: a (0,0) pixel is accepted in the cycle immediately after the last pixel, since SYNC is entered on that same edge.
- Outputs are stable for the whole of the next frame, so consumers sample them freely.
- Cycles with `pixel_valid` = 0 have no effect on any state.

## Test plan
- Single marker pixel (R=255, G=0, B=0) at (100,50), `p_min_count` = 1 → after the last pixel, all four corners = (100,50), `update` pulses once, `pixel_count` = 1, `corners_valid` = 1.
- Marker pixels at (200,100), (300,110), (190,300), (310,320) → TL = (200,100), TR = (300,110), BL = (190,300), BR = (310,320).
- Only 10 marker pixels with `p_min_count` = 16, after a good frame → corners hold the previous values, `corners_valid` = 0, `pixel_count` = 10, `update` pulses.
- Tie: markers at (10,20) then (20,10) (both s = 30) → TL = (10,20).
- Truncated frame: a new (0,0) arrives mid-scan after markers at (50,50) → no `update`; the next full frame reports only its own markers.
- Reset driven low mid-frame, then released → outputs equal the full-screen defaults; markers before the next (0,0) are ignored.

Source files
------------

// File: rtl/corner_if.sv
// Pixel-stream and corner-result bundle between a video source and corner_detect.
interface corner_if;
  // Pixel stream
  logic        pixel_valid;
  logic [10:0] VGA_X;
  logic [10:0] VGA_Y;
  logic [7:0]  R;
  logic [7:0]  G;
  logic [7:0]  B;

  // Per-frame results
  logic [10:0] top_left_x;
  logic [10:0] top_left_y;
  logic [10:0] top_right_x;
  logic [10:0] top_right_y;
  logic [10:0] bot_left_x;
  logic [10:0] bot_left_y;
  logic [10:0] bot_right_x;
  logic [10:0] bot_right_y;
  logic        corners_valid;
  logic        update;
  logic [15:0] pixel_count;

  // Video source side: drives pixels, consumes corners
  modport master (
    output pixel_valid, VGA_X, VGA_Y, R, G, B,
    input  top_left_x, top_left_y, top_right_x, top_right_y,
    input  bot_left_x, bot_left_y, bot_right_x, bot_right_y,
    input  corners_valid, update, pixel_count
  );

  // Detector side
  modport slave (
    input  pixel_valid, VGA_X, VGA_Y, R, G, B,
    output top_left_x, top_left_y, top_right_x, top_right_y,
    output bot_left_x, bot_left_y, bot_right_x, bot_right_y,
    output corners_valid, update, pixel_count
  );
endinterface

// File: rtl/corner_detect.sv
// Per-frame marker corner finder. Classifies each active pixel by colour threshold and tracks
// the extreme marker pixels along the s = x+y and d = x-y diagonals; publishes them at frame end.
module corner_detect #(
  parameter int unsigned p_h_active  = 640,
  parameter int unsigned p_v_active  = 480,
  parameter logic [7:0]  p_r_min     = 8'd160,
  parameter logic [7:0]  p_g_max     = 8'd80,
  parameter logic [7:0]  p_b_max     = 8'd80,
  parameter logic [15:0] p_min_count = 16'd16
) (
  input  logic    clk,
  input  logic    reset,
  corner_if.slave bus
);

  localparam logic [10:0] HLast = 11'(p_h_active - 1);
  localparam logic [10:0] VLast = 11'(p_v_active - 1);

  typedef enum logic [0:0] {StSync, StScan} state_e;

  typedef struct packed {
    logic [11:0]        min_s;
    logic [11:0]        max_s;
    logic signed [11:0] min_d;
    logic signed [11:0] max_d;
    logic [10:0]        tl_x;
    logic [10:0]        tl_y;
    logic [10:0]        tr_x;
    logic [10:0]        tr_y;
    logic [10:0]        bl_x;
    logic [10:0]        bl_y;
    logic [10:0]        br_x;
    logic [10:0]        br_y;
    logic [15:0]        count;
  } acc_t;

  typedef struct packed {
    logic [10:0] tl_x;
    logic [10:0] tl_y;
    logic [10:0] tr_x;
    logic [10:0] tr_y;
    logic [10:0] bl_x;
    logic [10:0] bl_y;
    logic [10:0] br_x;
    logic [10:0] br_y;
  } corners_t;

  // Coordinates start at zero: any marker beats the initial keys except a lone (0,0) marker on
  // the s maximum, where bot_right = (0,0) is still the right answer.
  localparam acc_t AccInit = '{
    min_s: 12'hFFF, max_s: 12'h000, min_d: 12'sh7FF, max_d: 12'sh800,
    tl_x: 11'd0, tl_y: 11'd0, tr_x: 11'd0, tr_y: 11'd0,
    bl_x: 11'd0, bl_y: 11'd0, br_x: 11'd0, br_y: 11'd0,
    count: 16'd0
  };

  localparam corners_t CornersRst = '{
    tl_x: 11'd0,  tl_y: 11'd0,
    tr_x: HLast,  tr_y: 11'd0,
    bl_x: 11'd0,  bl_y: VLast,
    br_x: HLast,  br_y: VLast
  };

  state_e      state_q, state_d;
  acc_t        acc_q, acc_d;
  acc_t        acc_base, acc_fold;
  corners_t    corners_q, corners_d;
  logic        valid_q, valid_d;
  logic        update_q, update_d;
  logic [15:0] count_q, count_d;

  logic               accept;
  logic               is_origin;
  logic               is_last;
  logic               is_marker;
  logic [11:0]        key_s;
  logic signed [11:0] key_d;

  // Pixel classification and diagonal keys
  always_comb begin
    accept    = bus.pixel_valid && (bus.VGA_X <= HLast);
    is_origin = accept && (bus.VGA_X == 11'd0) && (bus.VGA_Y == 11'd0);
    is_last   = accept && (bus.VGA_X == HLast) && (bus.VGA_Y == VLast);
    is_marker = (bus.R >= p_r_min) && (bus.G <= p_g_max) && (bus.B <= p_b_max);
    key_s     = {1'b0, bus.VGA_X} + {1'b0, bus.VGA_Y};
    key_d     = $signed({1'b0, bus.VGA_X}) - $signed({1'b0, bus.VGA_Y});
  end

  // Fold the current pixel into the accumulators; (0,0) always starts from a clean slate
  always_comb begin
    acc_base = is_origin ? AccInit : acc_q;
    acc_fold = acc_base;
    if (is_marker) begin
      if (key_s < acc_base.min_s) begin
        acc_fold.min_s = key_s;
        acc_fold.tl_x  = bus.VGA_X;
        acc_fold.tl_y  = bus.VGA_Y;
      end
      if (key_s > acc_base.max_s) begin
        acc_fold.max_s = key_s;
        acc_fold.br_x  = bus.VGA_X;
        acc_fold.br_y  = bus.VGA_Y;
      end
      if (key_d > acc_base.max_d) begin
        acc_fold.max_d = key_d;
        acc_fold.tr_x  = bus.VGA_X;
        acc_fold.tr_y  = bus.VGA_Y;
      end
      if (key_d < acc_base.min_d) begin
        acc_fold.min_d = key_d;
        acc_fold.bl_x  = bus.VGA_X;
        acc_fold.bl_y  = bus.VGA_Y;
      end
      if (acc_base.count != 16'hFFFF) begin
        acc_fold.count = acc_base.count + 16'd1;
      end
    end
  end

  // Frame sequencing: next state, accumulator load and frame-end publication
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    corners_d = corners_q;
    valid_d   = valid_q;
    count_d   = count_q;
    update_d  = 1'b0;
    unique case (state_q)
      StSync: begin
        if (is_origin) begin
          acc_d   = acc_fold;
          state_d = StScan;
        end
      end
      StScan: begin
        if (is_last) begin
          // The last pixel is part of the published result
          if (acc_fold.count >= p_min_count) begin
            corners_d = '{
              tl_x: acc_fold.tl_x, tl_y: acc_fold.tl_y,
              tr_x: acc_fold.tr_x, tr_y: acc_fold.tr_y,
              bl_x: acc_fold.bl_x, bl_y: acc_fold.bl_y,
              br_x: acc_fold.br_x, br_y: acc_fold.br_y
            };
            valid_d = 1'b1;
          end else begin
            valid_d = 1'b0;
          end
          count_d  = acc_fold.count;
          update_d = 1'b1;
          acc_d    = AccInit;
          state_d  = StSync;
        end else if (accept) begin
          // A mid-frame (0,0) restarts the accumulators via acc_base and stays in scan
          acc_d = acc_fold;
        end
      end
      default: state_d = StSync;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StSync;
      acc_q     <= AccInit;
      corners_q <= CornersRst;
      valid_q   <= 1'b0;
      update_q  <= 1'b0;
      count_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      corners_q <= corners_d;
      valid_q   <= valid_d;
      update_q  <= update_d;
      count_q   <= count_d;
    end
  end

  assign bus.top_left_x    = corners_q.tl_x;
  assign bus.top_left_y    = corners_q.tl_y;
  assign bus.top_right_x   = corners_q.tr_x;
  assign bus.top_right_y   = corners_q.tr_y;
  assign bus.bot_left_x    = corners_q.bl_x;
  assign bus.bot_left_y    = corners_q.bl_y;
  assign bus.bot_right_x   = corners_q.br_x;
  assign bus.bot_right_y   = corners_q.br_y;
  assign bus.corners_valid = valid_q;
  assign bus.update        = update_q;
  assign bus.pixel_count   = count_q;

endmodule

// File: tb/tb_corner_detect.sv
// Directed bench for corner_detect: two instances (minimum count 1 and 16) see the same stream;
// a behavioural model pushes expected frame results, popped when update is expected.
module tb_corner_detect;

  logic clk;
  logic reset;

  corner_if ifa ();
  corner_if ifb ();

  corner_detect #(.p_min_count(16'd1)) u_dut_a (.clk(clk), .reset(reset), .bus(ifa));
  corner_detect #(.p_min_count(16'd16)) u_dut_b (.clk(clk), .reset(reset), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    integer tl_x, tl_y, tr_x, tr_y, bl_x, bl_y, br_x, br_y, cnt, vld;
  } exp_t;

  int checks = 0;
  int errors = 0;

  exp_t dflt;
  exp_t cur_a, cur_b, pend_a, pend_b;
  exp_t qa[$];
  exp_t qb[$];

  // Behavioural model state
  bit     m_scan;
  bit     m_upd;
  integer m_min_s, m_max_s, m_min_d, m_max_d, m_cnt;
  integer m_tl_x, m_tl_y, m_tr_x, m_tr_y, m_bl_x, m_bl_y, m_br_x, m_br_y;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  task automatic cmp(input string who, input exp_t o, input exp_t e);
    chk({who, ".tl_x"}, o.tl_x, e.tl_x);
    chk({who, ".tl_y"}, o.tl_y, e.tl_y);
    chk({who, ".tr_x"}, o.tr_x, e.tr_x);
    chk({who, ".tr_y"}, o.tr_y, e.tr_y);
    chk({who, ".bl_x"}, o.bl_x, e.bl_x);
    chk({who, ".bl_y"}, o.bl_y, e.bl_y);
    chk({who, ".br_x"}, o.br_x, e.br_x);
    chk({who, ".br_y"}, o.br_y, e.br_y);
    chk({who, ".pixel_count"}, o.cnt, e.cnt);
    chk({who, ".corners_valid"}, o.vld, e.vld);
  endtask

  function automatic exp_t obs_a();
    exp_t o;
    o.tl_x = ifa.top_left_x;  o.tl_y = ifa.top_left_y;
    o.tr_x = ifa.top_right_x; o.tr_y = ifa.top_right_y;
    o.bl_x = ifa.bot_left_x;  o.bl_y = ifa.bot_left_y;
    o.br_x = ifa.bot_right_x; o.br_y = ifa.bot_right_y;
    o.cnt  = ifa.pixel_count; o.vld  = ifa.corners_valid;
    return o;
  endfunction

  function automatic exp_t obs_b();
    exp_t o;
    o.tl_x = ifb.top_left_x;  o.tl_y = ifb.top_left_y;
    o.tr_x = ifb.top_right_x; o.tr_y = ifb.top_right_y;
    o.bl_x = ifb.bot_left_x;  o.bl_y = ifb.bot_left_y;
    o.br_x = ifb.bot_right_x; o.br_y = ifb.bot_right_y;
    o.cnt  = ifb.pixel_count; o.vld  = ifb.corners_valid;
    return o;
  endfunction

  task automatic m_init();
    m_min_s = 4095; m_max_s = 0; m_min_d = 2047; m_max_d = -2048; m_cnt = 0;
    m_tl_x = 0; m_tl_y = 0; m_tr_x = 0; m_tr_y = 0;
    m_bl_x = 0; m_bl_y = 0; m_br_x = 0; m_br_y = 0;
  endtask

  task automatic m_fold(input int x, input int y, input int r, input int g, input int b);
    int s, d;
    if (r >= 160 && g <= 80 && b <= 80) begin
      s = x + y;
      d = x - y;
      if (s < m_min_s) begin m_min_s = s; m_tl_x = x; m_tl_y = y; end
      if (s > m_max_s) begin m_max_s = s; m_br_x = x; m_br_y = y; end
      if (d > m_max_d) begin m_max_d = d; m_tr_x = x; m_tr_y = y; end
      if (d < m_min_d) begin m_min_d = d; m_bl_x = x; m_bl_y = y; end
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  function automatic exp_t m_end(input exp_t prev, input int minc);
    exp_t e;
    e = prev;
    if (m_cnt >= minc) begin
      e.tl_x = m_tl_x; e.tl_y = m_tl_y; e.tr_x = m_tr_x; e.tr_y = m_tr_y;
      e.bl_x = m_bl_x; e.bl_y = m_bl_y; e.br_x = m_br_x; e.br_y = m_br_y;
      e.vld  = 1;
    end else begin
      e.vld = 0;
    end
    e.cnt = m_cnt;
    return e;
  endfunction

  task automatic model_px(input int x, input int y, input int r, input int g, input int b);
    bit origin, last;
    if (x >= 640) return;
    origin = (x == 0) && (y == 0);
    last   = (x == 639) && (y == 479);
    if (!m_scan) begin
      if (origin) begin m_init(); m_fold(x, y, r, g, b); m_scan = 1; end
    end else if (origin) begin
      m_init();
      m_fold(x, y, r, g, b);
    end else begin
      m_fold(x, y, r, g, b);
      if (last) begin
        pend_a = m_end(pend_a, 1);
        qa.push_back(pend_a);
        pend_b = m_end(pend_b, 16);
        qb.push_back(pend_b);
        m_upd  = 1;
        m_scan = 0;
        m_init();
      end
    end
  endtask

  task automatic model_reset();
    m_scan = 0; m_upd = 0; m_init();
    qa.delete(); qb.delete();
    cur_a = dflt; cur_b = dflt; pend_a = dflt; pend_b = dflt;
  endtask

  // Compare both instances against the expected held state, popping a frame result on update
  task automatic step_check();
    exp_t oa, ob;
    oa = obs_a();
    ob = obs_b();
    chk("a.update", ifa.update, m_upd);
    chk("b.update", ifb.update, m_upd);
    if (m_upd) begin
      chk("a.queue_nonempty", qa.size() > 0, 1);
      chk("b.queue_nonempty", qb.size() > 0, 1);
      if (qa.size() > 0) cur_a = qa.pop_front();
      if (qb.size() > 0) cur_b = qb.pop_front();
    end
    m_upd = 0;
    cmp("a", oa, cur_a);
    cmp("b", ob, cur_b);
  endtask

  task automatic set_bus(input bit v, input int x, input int y, input int r, input int g,
                         input int b);
    ifa.pixel_valid = v;      ifb.pixel_valid = v;
    ifa.VGA_X = 11'(x);       ifb.VGA_X = 11'(x);
    ifa.VGA_Y = 11'(y);       ifb.VGA_Y = 11'(y);
    ifa.R = 8'(r);            ifb.R = 8'(r);
    ifa.G = 8'(g);            ifb.G = 8'(g);
    ifa.B = 8'(b);            ifb.B = 8'(b);
  endtask

  // One valid pixel for one clock
  task automatic px(input int x, input int y, input int r, input int g, input int b);
    set_bus(1'b1, x, y, r, g, b);
    model_px(x, y, r, g, b);
    @(posedge clk);
    #1;
    set_bus(1'b0, 639, 479, 255, 0, 0);
    step_check();
  endtask

  task automatic mk(input int x, input int y);
    px(x, y, 255, 0, 0);
  endtask

  task automatic bg(input int x, input int y);
    px(x, y, 0, 0, 0);
  endtask

  // Idle cycles carry a marker-coloured last-pixel coordinate with valid low
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_bus(1'b0, 639, 479, 255, 0, 0);
      @(posedge clk);
      #1;
      step_check();
    end
  endtask

  initial begin
    dflt = '{tl_x: 0, tl_y: 0, tr_x: 639, tr_y: 0, bl_x: 0, bl_y: 479,
             br_x: 639, br_y: 479, cnt: 0, vld: 0};
    reset = 1'b0;
    set_bus(1'b0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    step_check();
    reset = 1'b1;
    idle(2);

    // Single marker; out-of-range marker at X=700 is ignored
    bg(0, 0);
    idle(1);
    mk(100, 50);
    mk(700, 60);
    bg(639, 479);
    idle(3);

    // Four spread markers plus twelve fillers, then a back-to-back frame
    bg(0, 0);
    mk(200, 100);
    mk(300, 110);
    for (int i = 0; i < 12; i++) mk(250 + i, 200);
    mk(190, 300);
    mk(310, 320);
    bg(639, 479);

    // Ten markers with an s tie and colour-threshold boundaries
    bg(0, 0);
    mk(10, 20);
    mk(20, 10);
    px(500, 5, 160, 80, 80);
    px(600, 400, 159, 0, 0);
    px(601, 400, 200, 81, 0);
    px(602, 400, 200, 0, 81);
    for (int i = 0; i < 7; i++) mk(400 + i, 300);
    bg(639, 479);
    idle(2);

    // Truncated frame: restart at (0,0) after a marker
    bg(0, 0);
    mk(50, 50);
    idle(2);
    bg(0, 0);
    mk(60, 70);
    bg(639, 479);
    idle(2);

    // Reset mid-frame, then markers before the next (0,0) are ignored
    bg(0, 0);
    mk(5, 5);
    reset = 1'b0;
    model_reset();
    #1;
    step_check();
    @(posedge clk);
    #1;
    step_check();
    reset = 1'b1;
    idle(1);
    mk(30, 30);
    bg(639, 479);
    idle(1);
    bg(0, 0);
    mk(77, 88);
    bg(639, 479);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
